// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and the register-dependency stall rule for the hazard controller.
package hazard_ctrl_pkg;

  localparam logic [1:0]  TUSE_NONE = 2'd3;
  localparam int unsigned MULT_CYC  = 5;
  localparam int unsigned DIV_CYC   = 10;
  localparam int unsigned CNT_W     = 4;

  // A source stalls only when a producer in E or M targets it and its result
  // will not be ready by the time D needs it; $0 and unused sources never stall.
  function automatic logic src_stall(input logic [4:0] src,
                                     input logic [1:0] tuse,
                                     input logic [4:0] e_dst,
                                     input logic [1:0] e_tnew,
                                     input logic [4:0] m_dst,
                                     input logic [1:0] m_tnew);
    logic hit_e;
    logic hit_m;
    hit_e = (src == e_dst) && (e_tnew > tuse);
    hit_m = (src == m_dst) && (m_tnew > tuse);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/md_timer.sv
// Busy-window down-counter for the mult/div unit; a start is accepted only when idle.
module md_timer #(
  parameter int unsigned MULT_CYC = hazard_ctrl_pkg::MULT_CYC,
  parameter int unsigned DIV_CYC  = hazard_ctrl_pkg::DIV_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);
  import hazard_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] md_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end else if (load) begin
      md_cnt <= is_div ? DIV_LOAD : MULT_LOAD;
    end
  end

  assign busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational D-stage stall decision, mult/div busy
// tracking and a saturating count of stalled cycles.
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = hazard_ctrl_pkg::MULT_CYC,
  parameter int unsigned DIV_CYC  = hazard_ctrl_pkg::DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic [4:0]  E_dst,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_dst,
  input  logic [1:0]  M_tnew,
  input  logic        D_md_use,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_clr,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);
  import hazard_ctrl_pkg::*;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall;

  md_timer #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC)
  ) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .load  (E_md_start),
    .is_div(E_md_div),
    .busy  (md_busy)
  );

  assign stall_rs = src_stall(D_rs, D_tuse_rs, E_dst, E_tnew, M_dst, M_tnew);
  assign stall_rt = src_stall(D_rt, D_tuse_rt, E_dst, E_tnew, M_dst, M_tnew);
  // A start in E blocks D the same cycle, before md_busy has risen.
  assign stall_md = D_md_use && (md_busy || E_md_start);
  assign stall    = stall_rs || stall_rt || stall_md;

  assign pc_en  = !stall;
  assign fd_en  = !stall;
  assign de_clr = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-indexed reference model.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_dst, M_dst;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_md_use, E_md_start, E_md_div;
  logic        pc_en, fd_en, de_clr, md_busy;
  logic [15:0] stall_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .D_rs      (D_rs),
    .D_rt      (D_rt),
    .D_tuse_rs (D_tuse_rs),
    .D_tuse_rt (D_tuse_rt),
    .E_dst     (E_dst),
    .E_tnew    (E_tnew),
    .M_dst     (M_dst),
    .M_tnew    (M_tnew),
    .D_md_use  (D_md_use),
    .E_md_start(E_md_start),
    .E_md_div  (E_md_div),
    .pc_en     (pc_en),
    .fd_en     (fd_en),
    .de_clr    (de_clr),
    .md_busy   (md_busy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    else
      pass_cnt++;
  endtask

  // Model: cycle index, last cycle of the current busy window, and raw stall total.
  longint cyc          = 0;
  longint busy_through = -1;
  int     stall_sum    = 0;

  function automatic bit src_hit(input int src, input int tuse);
    return (src != 0) && ((src == int'(E_dst) && int'(E_tnew) > tuse) ||
                          (src == int'(M_dst) && int'(M_tnew) > tuse));
  endfunction

  function automatic bit m_busy();
    return cyc <= busy_through;
  endfunction

  function automatic bit m_stall();
    return src_hit(int'(D_rs), int'(D_tuse_rs)) || src_hit(int'(D_rt), int'(D_tuse_rt)) ||
           (D_md_use && (m_busy() || E_md_start));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      stall_sum = 0;
      if (busy_through > cyc) busy_through = cyc;
    end else begin
      if (m_stall()) stall_sum++;
      if (E_md_start && !m_busy())
        busy_through = cyc + (E_md_div ? DIV_N : MULT_N);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("model_pc_en",  {31'd0, pc_en},  {31'd0, !m_stall()});
      chk("model_fd_en",  {31'd0, fd_en},  {31'd0, !m_stall()});
      chk("model_de_clr", {31'd0, de_clr}, {31'd0, m_stall()});
      chk("model_md_busy", {31'd0, md_busy}, {31'd0, m_busy()});
      chk("model_stall_cnt", {16'd0, stall_cnt},
          (stall_sum > 65535) ? 32'hFFFF : 32'(stall_sum));
    end
  end

  task automatic neutral();
    D_rs = 0; D_rt = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
    E_dst = 0; E_tnew = 0; M_dst = 0; M_tnew = 0;
    D_md_use = 0; E_md_start = 0; E_md_div = 0;
  endtask

  task automatic nxt(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int busy_seen;

  initial begin
    neutral();
    reset = 1'b1;
    nxt(1);
    smp();
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
    chk("rst_de_clr", {31'd0, de_clr}, 32'd0);
    nxt(2);
    reset = 1'b0;
    smp();
    chk("idle_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    nxt(1);

    // Load-use on rs from E
    D_rs = 5; D_tuse_rs = 1; E_dst = 5; E_tnew = 2;
    smp();
    chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
    chk("lu_fd_en", {31'd0, fd_en}, 32'd0);
    chk("lu_de_clr", {31'd0, de_clr}, 32'd1);
    chk("lu_cnt_before", {16'd0, stall_cnt}, 32'd0);
    nxt(1);
    neutral();
    smp();
    chk("lu_cnt_after", {16'd0, stall_cnt}, 32'd1);
    nxt(1);

    // $0 is never a hazard
    D_rs = 0; D_tuse_rs = 0; E_dst = 0; E_tnew = 2;
    smp();
    chk("zero_reg_pc_en", {31'd0, pc_en}, 32'd1);
    nxt(1);
    neutral();
    // Result in M already available
    D_rt = 3; D_tuse_rt = 0; M_dst = 3; M_tnew = 0;
    smp();
    chk("fwd_m_pc_en", {31'd0, pc_en}, 32'd1);
    nxt(1);
    // More data patterns, checked by the model
    M_tnew = 1;                                          // rt from M, not ready: stall
    nxt(1);
    neutral(); D_rs = 7; D_tuse_rs = 1; E_dst = 7; E_tnew = 1;  // tnew == tuse: no stall
    nxt(1);
    D_tuse_rs = 2'd3; E_tnew = 2;                        // unused source: no stall
    smp();
    chk("tuse_none_pc_en", {31'd0, pc_en}, 32'd1);
    nxt(1);
    neutral(); D_rt = 9; D_tuse_rt = 1; M_dst = 9; M_tnew = 2;  // rt from M: stall
    nxt(1);
    // Data and md stall together count once
    neutral(); D_rs = 4; D_tuse_rs = 0; E_dst = 4; E_tnew = 1;
    D_md_use = 1; E_md_start = 1; E_md_div = 0;
    nxt(1);
    neutral();
    nxt(MULT_N + 1);

    // Mult window with D_md_use held
    for (int k = 0; k <= 7; k++) begin
      D_md_use = 1; E_md_start = (k == 0); E_md_div = 0;
      smp();
      chk($sformatf("mult_de_clr_k%0d", k), {31'd0, de_clr}, {31'd0, k <= 5});
      chk($sformatf("mult_busy_k%0d", k), {31'd0, md_busy}, {31'd0, (k >= 1) && (k <= 5)});
      nxt(1);
    end
    neutral();
    nxt(1);

    // Div window with an ignored mult start at busy cycle 3
    E_md_start = 1; E_md_div = 1;
    nxt(1);
    busy_seen = 0;
    for (int k = 1; k <= 13; k++) begin
      E_md_start = (k == 3); E_md_div = 0;
      smp();
      if (md_busy) busy_seen++;
      nxt(1);
    end
    chk("div_busy_len", 32'(busy_seen), 32'd10);
    neutral();
    nxt(1);

    // Reset in the middle of a div window
    D_md_use = 1; E_md_start = 1; E_md_div = 1;
    nxt(1);
    E_md_start = 0;
    nxt(3);
    reset = 1'b1;
    smp();
    chk("rstdiv_busy_during", {31'd0, md_busy}, 32'd1);
    nxt(1);
    reset = 1'b0;
    smp();
    chk("rstdiv_busy_after", {31'd0, md_busy}, 32'd0);
    chk("rstdiv_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rstdiv_pc_en", {31'd0, pc_en}, 32'd1);
    nxt(1);
    neutral();

    // Saturation
    D_rs = 5; D_tuse_rs = 0; E_dst = 5; E_tnew = 2;
    nxt(65540);
    smp();
    chk("sat_value", {16'd0, stall_cnt}, 32'hFFFF);
    nxt(3);
    smp();
    chk("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
    chk("sat_pc_en", {31'd0, pc_en}, 32'd0);
    nxt(1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
